// File: rtl/approx_adder_pipe.sv
// approx_adder_pipe: two-stage pipelined approximate adder with a runtime mode
// (exact, lower-part-OR, segmented carry-cut) and on-line error statistics.
module approx_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int APX   = 4,
  parameter int SEG   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  input  logic             stat_clr,
  output logic             out_valid,
  output logic [WIDTH:0]   Sum,
  output logic [WIDTH:0]   Exact,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count,
  output logic [WIDTH:0]   max_err
);

  localparam int UW   = WIDTH - APX;
  localparam int NSEG = WIDTH / SEG;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_LOA   = 2'd1,
    MODE_SEG   = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  // stage-1 registers
  logic             v1;
  mode_t            m1;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic             c1;

  // stage-2 combinational results
  logic [WIDTH:0]   exact_c;
  logic [UW:0]      loa_hi;
  logic [WIDTH:0]   loa_sum;
  logic [SEG:0]     seg_tmp;
  logic [WIDTH:0]   seg_sum;
  logic [WIDTH:0]   apx_sum;
  logic [WIDTH:0]   err_mag;
  logic             err_c;

  // capture every input each cycle; no back-pressure
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      m1 <= MODE_EXACT;
      x1 <= '0;
      y1 <= '0;
      c1 <= 1'b0;
    end else begin
      v1 <= in_valid;
      m1 <= mode_t'(mode);
      x1 <= X;
      y1 <= Y;
      c1 <= Cin;
    end
  end

  // exact reference sum
  always_comb begin
    exact_c = {1'b0, x1} + {1'b0, y1} + {{WIDTH{1'b0}}, c1};
  end

  // lower-part OR: low bits ORed, upper part fed by AND of the top low bits
  always_comb begin
    loa_hi  = {1'b0, x1[WIDTH-1:APX]} + {1'b0, y1[WIDTH-1:APX]}
            + {{UW{1'b0}}, x1[APX-1] & y1[APX-1]};
    loa_sum = {loa_hi, x1[APX-1:0] | y1[APX-1:0]};
  end

  // segmented carry-cut: each segment adds on its own, Cin enters segment 0 only,
  // and only the top segment's carry-out survives as the MSB
  always_comb begin
    seg_sum = '0;
    seg_tmp = '0;
    for (int unsigned j = 0; j < NSEG; j++) begin
      seg_tmp = {1'b0, x1[j*SEG +: SEG]} + {1'b0, y1[j*SEG +: SEG]}
              + ((j == 0) ? {{SEG{1'b0}}, c1} : {(SEG+1){1'b0}});
      seg_sum[j*SEG +: SEG] = seg_tmp[SEG-1:0];
      if (j == NSEG - 1) seg_sum[WIDTH] = seg_tmp[SEG];
    end
  end

  // mode select and error magnitude
  always_comb begin
    case (m1)
      MODE_LOA: apx_sum = loa_sum;
      MODE_SEG: apx_sum = seg_sum;
      default:  apx_sum = exact_c;
    endcase
    err_mag = (apx_sum >= exact_c) ? (apx_sum - exact_c) : (exact_c - apx_sum);
    err_c   = (err_mag != '0);
  end

  // output register; results hold while no valid sample retires
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      Exact     <= '0;
      err_flag  <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        Sum      <= apx_sum;
        Exact    <= exact_c;
        err_flag <= err_c;
      end
    end
  end

  // saturating statistics; clear takes priority over the retiring sample
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      err_count    <= '0;
      sample_count <= '0;
      max_err      <= '0;
    end else if (stat_clr) begin
      err_count    <= '0;
      sample_count <= '0;
      max_err      <= '0;
    end else if (v1) begin
      if (sample_count != '1) sample_count <= sample_count + CNT_ONE;
      if (err_c && (err_count != '1)) err_count <= err_count + CNT_ONE;
      if (err_mag > max_err) max_err <= err_mag;
    end
  end

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Randomised bench for approx_adder_pipe with a sample-level reference model.
// A second instance with 4-bit counters shares the stimulus to cover saturation.
module tb_approx_adder_pipe;

  localparam int W = 8;
  localparam int A = 4;
  localparam int S = 4;

  logic         clock = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [1:0]   mode;
  logic [W-1:0] X, Y;
  logic         Cin;
  logic         stat_clr;

  logic         out_valid, err_flag;
  logic [W:0]   Sum, Exact, max_err;
  logic [15:0]  err_count, sample_count;

  logic         out_valid4, err_flag4;
  logic [W:0]   Sum4, Exact4, max_err4;
  logic [3:0]   err_count4, sample_count4;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  bit v_pend;
  int p_sum, p_exact;
  bit e_ov, e_err;
  int e_sum, e_exact, e_max;
  int sc16, ec16, sc4, ec4;

  always #5 clock = ~clock;

  approx_adder_pipe #(.WIDTH(W), .APX(A), .SEG(S), .CNT_W(16)) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
    .X(X), .Y(Y), .Cin(Cin), .stat_clr(stat_clr),
    .out_valid(out_valid), .Sum(Sum), .Exact(Exact), .err_flag(err_flag),
    .err_count(err_count), .sample_count(sample_count), .max_err(max_err)
  );

  approx_adder_pipe #(.WIDTH(W), .APX(A), .SEG(S), .CNT_W(4)) dut4 (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
    .X(X), .Y(Y), .Cin(Cin), .stat_clr(stat_clr),
    .out_valid(out_valid4), .Sum(Sum4), .Exact(Exact4), .err_flag(err_flag4),
    .err_count(err_count4), .sample_count(sample_count4), .max_err(max_err4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_sum(input int m, input int x, input int y, input int c);
    int r, t, xs, ys;
    case (m)
      1: begin
        r = ((x | y) % (1 << A))
          + (((x >> A) + (y >> A) + ((x >> (A-1)) & (y >> (A-1)) & 1)) << A);
      end
      2: begin
        r = 0;
        for (int j = 0; j < W/S; j++) begin
          xs = (x >> (j*S)) % (1 << S);
          ys = (y >> (j*S)) % (1 << S);
          t  = xs + ys + ((j == 0) ? c : 0);
          r += (t % (1 << S)) << (j*S);
          if (j == W/S - 1) r += (t >> S) << W;
        end
      end
      default: r = x + y + c;
    endcase
    return r;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic model_reset();
    v_pend = 0; p_sum = 0; p_exact = 0;
    e_ov = 0; e_err = 0; e_sum = 0; e_exact = 0; e_max = 0;
    sc16 = 0; ec16 = 0; sc4 = 0; ec4 = 0;
  endtask

  task automatic model_edge(input bit v, input int m, input int x, input int y,
                            input int c, input bit clr);
    int e;
    e_ov = v_pend;
    if (v_pend) begin
      e_sum = p_sum; e_exact = p_exact; e_err = (p_sum != p_exact);
    end
    e = (p_sum > p_exact) ? p_sum - p_exact : p_exact - p_sum;
    if (clr) begin
      sc16 = 0; ec16 = 0; sc4 = 0; ec4 = 0; e_max = 0;
    end else if (v_pend) begin
      sc16 = sat(sc16, 65535); sc4 = sat(sc4, 15);
      if (e != 0) begin ec16 = sat(ec16, 65535); ec4 = sat(ec4, 15); end
      if (e > e_max) e_max = e;
    end
    v_pend = v;
    if (v) begin
      p_sum = ref_sum(m, x, y, c);
      p_exact = x + y + c;
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(e_ov));
    check("sum", 32'(Sum), 32'(e_sum));
    check("exact", 32'(Exact), 32'(e_exact));
    check("err_flag", 32'(err_flag), 32'(e_err));
    check("err_count", 32'(err_count), 32'(ec16));
    check("sample_count", 32'(sample_count), 32'(sc16));
    check("max_err", 32'(max_err), 32'(e_max));
    check("sum_c4", 32'(Sum4), 32'(e_sum));
    check("valid_c4", 32'(out_valid4), 32'(e_ov));
    check("err_count_c4", 32'(err_count4), 32'(ec4));
    check("sample_count_c4", 32'(sample_count4), 32'(sc4));
    check("max_err_c4", 32'(max_err4), 32'(e_max));
    check("exact_c4", 32'(Exact4), 32'(e_exact));
    check("err_flag_c4", 32'(err_flag4), 32'(e_err));
  endtask

  task automatic step(input bit v, input int m, input int x, input int y,
                      input int c, input bit clr);
    @(negedge clock);
    in_valid = v; mode = 2'(m); X = W'(x); Y = W'(y); Cin = c[0]; stat_clr = clr;
    @(posedge clock);
    model_edge(v, m, x, y, c, clr);
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mode = '0; X = '0; Y = '0; Cin = 1'b0; stat_clr = 1'b0;
    model_reset();
    #2;
    compare_all();
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;

    // mode 0 carry through all bits
    step(1, 0, 'hFF, 'h01, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("m0_sum", 32'(Sum), 32'h100);
    check("m0_samples", 32'(sample_count), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    check("m0_single_pulse", 32'(out_valid), 32'd0);

    // LOA
    step(1, 1, 'h0F, 'h01, 0, 0);
    step(1, 1, 'hFF, 'h00, 1, 0);
    check("loa_sum", 32'(Sum), 32'h00F);
    check("loa_max", 32'(max_err), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    check("loa_sum_cin", 32'(Sum), 32'h0FF);
    check("loa_errs", 32'(err_count), 32'd2);

    // segmented
    step(1, 2, 'hFF, 'h01, 0, 0);
    step(1, 2, 'h11, 'h11, 0, 0);
    check("seg_sum", 32'(Sum), 32'h0F0);
    check("seg_max", 32'(max_err), 32'h010);
    step(0, 0, 0, 0, 0, 0);
    check("seg_sum2", 32'(Sum), 32'h022);
    check("seg_max_hold", 32'(max_err), 32'h010);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    // back-to-back with mode switch, clear on the 4th output
    step(1, 0, 'h12, 'h34, 1, 0);
    step(1, 1, 'h0F, 'h01, 0, 0);
    step(1, 2, 'hFF, 'h01, 0, 0);
    step(1, 0, 'hA5, 'h5A, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    check("b2b_4th_sum", 32'(Sum), 32'h100);
    check("b2b_cleared", 32'(sample_count), 32'd0);

    // counter saturation in the 4-bit instance
    repeat (20) step(1, 1, 'h0F, 'h01, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("sat4_samples", 32'(sample_count4), 32'd15);
    check("sat4_errs", 32'(err_count4), 32'd15);
    check("sat16_samples", 32'(sample_count), 32'd20);

    // randomised traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 1), ($urandom_range(0, 40) == 0));

    // asynchronous reset with samples in flight
    step(1, 1, 'h0F, 'h01, 0, 0);
    @(negedge clock);
    in_valid = 1'b1; mode = 2'd2; X = 8'hFF; Y = 8'h01; Cin = 1'b0; stat_clr = 1'b0;
    @(posedge clock);
    model_edge(1, 2, 'hFF, 'h01, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 'h01, 'h02, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("post_reset_sum", 32'(Sum), 32'h003);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/approx_adder_pipe.md
# approx_adder_pipe

Parametrised, pipelined approximate adder with runtime-selectable approximation mode and built-in accuracy monitoring; next generation of the team's 8-bit adder. Computes an exact and an approximate sum for every valid input pair. Registers the approximate result with a valid flag. Accumulates error statistics (mismatch count, sample count, maximum absolute error) for on-line characterisation in the approximate-computing flow.

## Interface
Parameters:
- WIDTH, 8, operand width; result is WIDTH+1 bits
- APX, 4, lower-part bits approximated in LOA mode; 0 < APX < WIDTH
- SEG, 4, segment width in carry-cut mode; WIDTH % SEG == 0
- CNT_W, 16, width of statistics counters

Ports:
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  input sample valid
- mode  in  2  0 exact, 1 lower-part-OR (LOA), 2 segmented carry-cut, 3 reserved (behaves as exact)
- X  in  WIDTH  operand
- Y  in  WIDTH  operand
- Cin  in  1  carry in
- stat_clr  in  1  synchronous clear of statistics
- out_valid  out  1  Sum/Exact/err_flag valid
- Sum  out  WIDTH+1  approximate result
- Exact  out  WIDTH+1  exact X+Y+Cin
- err_flag  out  1  Sum != Exact for this sample
- err_count  out  CNT_W  samples with err_flag=1, saturating
- sample_count  out  CNT_W  samples retired, saturating
- max_err  out  WIDTH+1  largest |Sum-Exact| since reset/clear

## Operation
- Stage 1 (input register): every cycle captures X, Y, Cin, mode, and v1 <= in_valid. No stall/back-pressure; one sample per cycle accepted.
- Stage 2 (compute/output register): from stage-1 values, computes Exact = X+Y+Cin (WIDTH+1 bits) and the approximate sum; registers Sum, Exact, err_flag, and out_valid <= v1.
- Sum, Exact and err_flag hold their last values while out_valid=0.
- Mode 0/3: Sum = Exact.
- Mode 1 (LOA):
  - Sum[APX-1:0] = X|Y on those bits; Cin is ignored.
  - Carry into the upper part = X[APX-1]&Y[APX-1].
  - Sum[WIDTH:APX] = X[WIDTH-1:APX]+Y[WIDTH-1:APX]+carry.
- Mode 2 (segmented):
  - Segment j (bits jSEG..jSEG+SEG-1) = X_j+Y_j+c_j mod 2^SEG.
  - c_0 = Cin, c_j = 0 for j>0; inter-segment carries are discarded.
  - Sum[WIDTH] = carry-out of the top segment.
- Error magnitude e = |Sum-Exact| as unsigned WIDTH+1-bit value; err_flag = (e != 0).
- Statistics update on the same edge that registers a valid stage-2 result (v1=1):
  - sample_count += 1.
  - err_count += err_flag.
  - max_err <= max(max_err, e).
  - Counters saturate at all-ones and never wrap.
- stat_clr=1: err_count, sample_count, max_err <= 0. Clear wins over a simultaneous update; the sample retiring that cycle is not counted. Its Sum/out_valid are still produced.
- mode is sampled per sample in stage 1; switching mode between back-to-back samples is legal and affects only samples captured after the change.

## Timing
- Latency: sample presented with in_valid=1 before rising edge N appears with out_valid=1 after edge N+1 (2 cycles). Throughput: 1 sample/cycle.
- Statistics reflect a sample in the same cycle its out_valid is high.
- Reset (rst_n low, asynchronous, any time):
  - All registers clear immediately: v1, out_valid, err_flag = 0; Sum, Exact = 0; err_count, sample_count, max_err = 0.
  - In-flight samples are discarded.
  - First valid output after release comes 2 edges after the first in_valid=1 sample.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
All with WIDTH=8, APX=4, SEG=4 unless noted.
- Mode 0, X=FF, Y=01, Cin=0, one-cycle in_valid -> two edges later out_valid=1 for exactly one cycle, Sum=Exact=0x100, err_flag=0, sample_count=1, err_count=0.
- Mode 1:
  - X=0F, Y=01, Cin=0 -> Sum=0x00F, Exact=0x010, err_flag=1, max_err=1.
  - Then X=FF, Y=00, Cin=1 -> Sum=0x0FF, Exact=0x100, err_count=2, max_err=1.
- Mode 2:
  - X=FF, Y=01, Cin=0 -> Sum=0x0F0, Exact=0x100, max_err=0x010.
  - Then X=11, Y=11, Cin=0 -> Sum=0x022, err_flag=0, max_err remains 0x010.
- Back-to-back stream of 4 samples, modes 0,1,2,0, in_valid held high -> 4 consecutive out_valid cycles in order, sample_count=4.
  - Pulse stat_clr on the 4th output cycle -> all stats 0 afterward, 4th Sum still correct.
- CNT_W=4, 20 consecutive erroring samples (mode 1, X=0F, Y=01) -> err_count and sample_count stop at 15.
- Assert rst_n low while two samples are in flight -> out_valid and all stats 0 immediately, no output for the dropped samples.
